// File: rtl/program_counter_stack.sv
// SAP program counter with jump load, call/return through a LIFO return stack,
// and sticky error reporting. Optional wrap trap enabled by PC_WRAP_TRAP_EN.
module program_counter_stack #(
  parameter int               WIDTH      = 4,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                       CLK_bar,
  input  logic                       CLR_bar,
  input  logic                       Cp,
  input  logic                       Ep,
  input  logic                       Lp,
  input  logic                       Call,
  input  logic                       Ret,
  input  logic [WIDTH-1:0]           W_bus_in,
  output logic [WIDTH-1:0]           W_bus,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       err,
  output logic                       trap
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_INC,
    OP_LOAD,
    OP_CALL,
    OP_RET
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [SPW-1:0]   sp_m1;
  logic             err_q, err_d;
  logic             trap_d;
  logic             frozen;
  logic             push;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] stack_mem [DEPTH];

  // Ret > Call > Lp > Cp; only the winning command has any effect.
  always_comb begin
    op = OP_IDLE;
    if (Ret)       op = OP_RET;
    else if (Call) op = OP_CALL;
    else if (Lp)   op = OP_LOAD;
    else if (Cp)   op = OP_INC;
  end

  assign pc_inc      = pc_q + WIDTH'(1);
  assign sp_m1       = sp_q - SPW'(1);
  assign stack_full  = (sp_q == SPW'(DEPTH));
  assign stack_empty = (sp_q == '0);

`ifdef PC_WRAP_TRAP_EN
  logic trap_q;
  assign frozen = trap_q;
  assign trap   = trap_q;
`else
  assign frozen = 1'b0;
  assign trap   = 1'b0;
`endif

  always_comb begin
    pc_d   = pc_q;
    sp_d   = sp_q;
    err_d  = err_q;
    trap_d = 1'b0;
    push   = 1'b0;
    if (!frozen) begin
      case (op)
        OP_RET: begin
          if (stack_empty) begin
            err_d = 1'b1;
          end else begin
            pc_d = stack_mem[sp_m1[IW-1:0]];
            sp_d = sp_m1;
          end
        end
        OP_CALL: begin
          if (stack_full) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = W_bus_in;
            sp_d = sp_q + SPW'(1);
          end
        end
        OP_LOAD: pc_d = W_bus_in;
        OP_INC: begin
`ifdef PC_WRAP_TRAP_EN
          // Incrementing past the top address halts the PC instead of wrapping.
          if (pc_q == '1) trap_d = 1'b1;
          else            pc_d   = pc_inc;
`else
          pc_d = pc_inc;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_bar or negedge CLR_bar) begin
    if (!CLR_bar) begin
      pc_q  <= RESET_ADDR;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

`ifdef PC_WRAP_TRAP_EN
  always_ff @(posedge CLK_bar or negedge CLR_bar) begin
    if (!CLR_bar)    trap_q <= 1'b0;
    else if (trap_d) trap_q <= 1'b1;
  end
`else
  logic unused_trap;
  assign unused_trap = trap_d;
`endif

  // Return addresses need no reset: an entry is only read after being pushed.
  always_ff @(posedge CLK_bar) begin
    if (push) stack_mem[sp_q[IW-1:0]] <= pc_inc;
  end

  assign pc    = pc_q;
  assign sp    = sp_q;
  assign err   = err_q;
  assign W_bus = Ep ? pc_q : {WIDTH{1'bz}};

endmodule
